// File: rtl/alu_exec_unit.sv
// MIPS execution unit: combinational ALU on ALUControl plus HI/LO registers and an
// iterative multiply/divide engine that is built only when ALU_MULDIV_EN is defined.
module alu_exec_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [4:0]       Shamt,
    input  logic [3:0]       ALUControl,
    input  logic             MDStart,
    input  logic [1:0]       MDOp,
    input  logic             HIWrite,
    input  logic             LOWrite,
    input  logic [WIDTH-1:0] WData,
    output logic [WIDTH-1:0] Result,
    output logic             Zero,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO,
    output logic             Busy,
    output logic             MDDone
);
    localparam int CW = $clog2(WIDTH);

    logic             md_wr;
    logic [WIDTH-1:0] md_hi;
    logic [WIDTH-1:0] md_lo;

    always_comb begin
        Result = '0;
        case (ALUControl)
            4'b0000: Result = A & B;
            4'b0001: Result = A | B;
            4'b0010: Result = A + B;
            4'b0110: Result = A - B;
            4'b0100: Result = A ^ B;
            4'b1100: Result = ~(A | B);
            4'b0111: Result = {{(WIDTH-1){1'b0}}, $signed(A) < $signed(B)};
            4'b1001: Result = {{(WIDTH-1){1'b0}}, A < B};
            4'b1110: Result = B << Shamt;
            4'b1111: Result = B >> Shamt;
            4'b1011: Result = $signed(B) >>> Shamt;
            4'b1010: Result = {B[15:0], {(WIDTH-16){1'b0}}};
            default: Result = '0;
        endcase
    end

    assign Zero = (Result == '0);

    // The engine's completing write wins; MTHI/MTLO land only while the engine is idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            HI <= '0;
            LO <= '0;
        end else if (md_wr) begin
            HI <= md_hi;
            LO <= md_lo;
        end else if (!Busy) begin
            if (HIWrite) HI <= WData;
            if (LOWrite) LO <= WData;
        end
    end

`ifdef ALU_MULDIV_EN
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} md_state_t;

    md_state_t          state;
    md_state_t          state_next;
    logic [CW-1:0]      cnt;
    logic               is_div;
    logic               neg_q;
    logic               neg_r;
    logic               b_zero;
    logic [WIDTH-1:0]   a_lat;
    logic [WIDTH-1:0]   mag_b;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_step;
    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     shifted;
    logic [WIDTH:0]     diff;
    logic               start;
    logic               last;
    logic               op_signed;
    logic [WIDTH-1:0]   mag_a_in;
    logic [WIDTH-1:0]   mag_b_in;

    assign start     = MDStart && (state != S_RUN);
    assign last      = (state == S_RUN) && (cnt == CW'(WIDTH-1));
    assign op_signed = ~MDOp[0];
    assign mag_a_in  = (op_signed && A[WIDTH-1]) ? -A : A;
    assign mag_b_in  = (op_signed && B[WIDTH-1]) ? -B : B;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        Busy       = 1'b0;
        MDDone     = 1'b0;
        case (state)
            S_IDLE: if (MDStart) state_next = S_RUN;
            S_RUN: begin
                Busy = 1'b1;
                if (last) state_next = S_DONE;
            end
            S_DONE: begin
                MDDone     = 1'b1;
                state_next = MDStart ? S_RUN : S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // acc holds {product_hi, multiplier} for multiply and {remainder, quotient} for divide.
    always_comb begin
        sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mag_b} : '0);
        shifted = acc[2*WIDTH-1:WIDTH-1];
        diff    = shifted - {1'b0, mag_b};
        if (is_div)
            acc_step = diff[WIDTH] ? {shifted[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                   : {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        else
            acc_step = {sum, acc[WIDTH-1:1]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            b_zero <= 1'b0;
            a_lat  <= '0;
            mag_b  <= '0;
            acc    <= '0;
        end else if (start) begin
            cnt    <= '0;
            is_div <= MDOp[1];
            neg_q  <= op_signed && (A[WIDTH-1] ^ B[WIDTH-1]);
            neg_r  <= op_signed && A[WIDTH-1];
            b_zero <= (B == '0);
            a_lat  <= A;
            mag_b  <= mag_b_in;
            acc    <= {{WIDTH{1'b0}}, mag_a_in};
        end else if (state == S_RUN) begin
            cnt <= cnt + 1'b1;
            acc <= acc_step;
        end
    end

    always_comb begin
        md_wr = last;
        md_hi = '0;
        md_lo = '0;
        if (!is_div) begin
            {md_hi, md_lo} = neg_q ? -acc_step : acc_step;
        end else if (b_zero) begin
            md_hi = a_lat;
            md_lo = '1;
        end else begin
            md_lo = neg_q ? -acc_step[WIDTH-1:0] : acc_step[WIDTH-1:0];
            md_hi = neg_r ? -acc_step[2*WIDTH-1:WIDTH] : acc_step[2*WIDTH-1:WIDTH];
        end
    end
`else
    logic unused_md;

    assign unused_md = ^{MDStart, MDOp};
    assign Busy      = 1'b0;
    assign MDDone    = 1'b0;
    assign md_wr     = 1'b0;
    assign md_hi     = '0;
    assign md_lo     = '0;
`endif

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit: a cycle-level behavioural model checked every
// negedge, plus literal expectations for the ALU sweep and each mul/div case.
module tb_alu_exec_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic [4:0]  Shamt = '0;
    logic [3:0]  ALUControl = '0;
    logic        MDStart = 1'b0;
    logic [1:0]  MDOp = '0;
    logic        HIWrite = 1'b0;
    logic        LOWrite = 1'b0;
    logic [31:0] WData = '0;
    logic [31:0] Result;
    logic        Zero;
    logic [31:0] HI;
    logic [31:0] LO;
    logic        Busy;
    logic        MDDone;

    int checks = 0;
    int errors = 0;

    alu_exec_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .A(A), .B(B), .Shamt(Shamt),
        .ALUControl(ALUControl), .MDStart(MDStart), .MDOp(MDOp),
        .HIWrite(HIWrite), .LOWrite(LOWrite), .WData(WData),
        .Result(Result), .Zero(Zero), .HI(HI), .LO(LO),
        .Busy(Busy), .MDDone(MDDone)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] alu_model(input logic [3:0] code, input logic [31:0] a,
                                              input logic [31:0] b, input logic [4:0] sh);
        logic [31:0] fill;
        fill = b[31] ? ~(32'hFFFF_FFFF >> sh) : 32'h0;
        case (code)
            4'h0: return a & b;
            4'h1: return a | b;
            4'h2: return a + b;
            4'h6: return a - b;
            4'h4: return a ^ b;
            4'hC: return ~(a | b);
            4'h7: return (longint'($signed(a)) < longint'($signed(b))) ? 32'd1 : 32'd0;
            4'h9: return (a < b) ? 32'd1 : 32'd0;
            4'hE: return b << sh;
            4'hF: return b >> sh;
            4'hB: return (b >> sh) | fill;
            4'hA: return b * 32'h0001_0000;
            default: return 32'h0;
        endcase
    endfunction

    task automatic md_model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                            output logic [31:0] hi, output logic [31:0] lo);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        logic [63:0]        p;
        sa = $signed(a);
        sb = $signed(b);
        if (op == 2'b00) begin
            p = sa * sb;
            {hi, lo} = p;
        end else if (op == 2'b01) begin
            p = {32'h0, a} * {32'h0, b};
            {hi, lo} = p;
        end else if (b == 32'h0) begin
            hi = a;
            lo = 32'hFFFF_FFFF;
        end else if (op == 2'b10) begin
            p  = sa / sb;
            lo = p[31:0];
            p  = sa % sb;
            hi = p[31:0];
        end else begin
            lo = a / b;
            hi = a % b;
        end
    endtask

    // Behavioural model: a busy window of 32 edges after acceptance, then one done cycle.
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;
    logic [31:0] pend_hi = '0;
    logic [31:0] pend_lo = '0;
    logic        m_busy = 1'b0;
    logic        m_done = 1'b0;
    int          m_left = 0;

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_hi = '0; m_lo = '0; m_busy = 1'b0; m_done = 1'b0; m_left = 0;
            end else begin
                m_done = 1'b0;
                if (m_busy) begin
                    m_left--;
                    if (m_left == 0) begin
                        m_hi = pend_hi; m_lo = pend_lo;
                        m_busy = 1'b0; m_done = 1'b1;
                    end
                end else begin
                    if (HIWrite) m_hi = WData;
                    if (LOWrite) m_lo = WData;
`ifdef ALU_MULDIV_EN
                    if (MDStart) begin
                        md_model(MDOp, A, B, pend_hi, pend_lo);
                        m_busy = 1'b1;
                        m_left = 32;
                    end
`endif
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("cyc_result", Result, alu_model(ALUControl, A, B, Shamt));
        chk("cyc_zero", {31'h0, Zero}, {31'h0, alu_model(ALUControl, A, B, Shamt) == 32'h0});
        chk("cyc_hi", HI, m_hi);
        chk("cyc_lo", LO, m_lo);
        chk("cyc_busy", {31'h0, Busy}, {31'h0, m_busy});
        chk("cyc_mddone", {31'h0, MDDone}, {31'h0, m_done});
    end

    task automatic set_alu(input logic [3:0] code, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] sh);
        @(posedge clk); #2;
        ALUControl = code; A = a; B = b; Shamt = sh;
    endtask

    task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        @(posedge clk); #2;
        MDOp = op; A = a; B = b; MDStart = 1'b1;
        @(posedge clk); #2;
        MDStart = 1'b0;
        A = $urandom; B = $urandom; MDOp = 2'($urandom_range(0, 3));
    endtask

    // Waits for MDDone (bounded), returning the number of sampled Busy cycles.
    task automatic wait_done(output int busy_cycles);
        int n;
        busy_cycles = (Busy === 1'b1) ? 1 : 0;
        n = 0;
        while (MDDone !== 1'b1 && n < 100) begin
            @(posedge clk); #2;
            n++;
            if (Busy === 1'b1) busy_cycles++;
        end
        chk("mddone_seen", {31'h0, MDDone}, 32'h1);
    endtask

    task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_hi,
                          input logic [31:0] exp_lo);
        int bc;
        start_op(op, a, b);
        wait_done(bc);
        chk({name, "_hi"}, HI, exp_hi);
        chk({name, "_lo"}, LO, exp_lo);
        chk({name, "_busy_cycles"}, bc, 32);
        @(posedge clk); #2;
        chk({name, "_done_one_cycle"}, {31'h0, MDDone}, 32'h0);
    endtask

    logic [3:0]  v_code [12] = '{4'h0, 4'h1, 4'h4, 4'hC, 4'h2, 4'h6,
                                 4'hD, 4'h7, 4'h9, 4'hB, 4'hA, 4'hE};
    logic [31:0] v_a    [12] = '{32'hF0F0F0F0, 32'hF0F0F0F0, 32'hF0F0F0F0, 32'hF0F0F0F0,
                                 32'hF0F0F0F0, 32'hF0F0F0F0, 32'hF0F0F0F0, 32'hFFFFFFFF,
                                 32'hFFFFFFFF, 32'h0, 32'h0, 32'h0};
    logic [31:0] v_b    [12] = '{32'h0FF00FF0, 32'h0FF00FF0, 32'h0FF00FF0, 32'h0FF00FF0,
                                 32'h0FF00FF0, 32'h0FF00FF0, 32'h0FF00FF0, 32'h1,
                                 32'h1, 32'h80000000, 32'h1234, 32'h1};
    logic [4:0]  v_sh   [12] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0,
                                 5'd0, 5'd0, 5'd0, 5'd4, 5'd0, 5'd31};
    logic [31:0] v_exp  [12] = '{32'h00F000F0, 32'hFFF0FFF0, 32'hFF00FF00, 32'h000F000F,
                                 32'h00E100E0, 32'hE100E100, 32'h0, 32'h1,
                                 32'h0, 32'hF8000000, 32'h12340000, 32'h80000000};

    initial begin
        int bc;
        int done_seen;
        #3;
        chk("reset_hi", HI, 32'h0);
        chk("reset_lo", LO, 32'h0);
        chk("reset_busy", {31'h0, Busy}, 32'h0);
        chk("reset_mddone", {31'h0, MDDone}, 32'h0);
        @(posedge clk); #2;
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            set_alu(v_code[i], v_a[i], v_b[i], v_sh[i]);
            #1;
            chk($sformatf("alu_vec%0d_result", i), Result, v_exp[i]);
            chk($sformatf("alu_vec%0d_zero", i), {31'h0, Zero}, {31'h0, v_exp[i] == 32'h0});
        end

`ifdef ALU_MULDIV_EN
        run_op("mult_neg3x7", 2'b00, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB);
        run_op("multu_max", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
        run_op("div_neg7by2", 2'b10, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
        run_op("divu_7by0", 2'b11, 32'd7, 32'd0, 32'd7, 32'hFFFFFFFF);
        run_op("div_min_by_m1", 2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000);

        // Second start and MTHI while busy are dropped; MTHI in the done cycle lands.
        start_op(2'b00, 32'd5, 32'd6);
        repeat (9) begin @(posedge clk); #2; end
        MDStart = 1'b1; MDOp = 2'b11; A = 32'd100; B = 32'd3;
        HIWrite = 1'b1; WData = 32'h00001111;
        @(posedge clk); #2;
        MDStart = 1'b0; HIWrite = 1'b0;
        wait_done(bc);
        chk("busy_ign_hi", HI, 32'h0);
        chk("busy_ign_lo", LO, 32'd30);
        HIWrite = 1'b1; WData = 32'h0000ABCD;
        @(posedge clk); #2;
        HIWrite = 1'b0;
        chk("done_cycle_mthi", HI, 32'h0000ABCD);
        chk("done_cycle_lo_kept", LO, 32'd30);
        chk("no_queued_start", {31'h0, Busy}, 32'h0);

        // Reset at cycle 15 of a DIV aborts it.
        start_op(2'b10, 32'd100, 32'd7);
        repeat (14) begin @(posedge clk); #2; end
        chk("pre_reset_busy", {31'h0, Busy}, 32'h1);
        #1 rst_n = 1'b0;
        #1;
        chk("midreset_busy", {31'h0, Busy}, 32'h0);
        chk("midreset_hi", HI, 32'h0);
        chk("midreset_lo", LO, 32'h0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        done_seen = 0;
        repeat (40) begin
            @(posedge clk); #2;
            if (MDDone === 1'b1) done_seen++;
        end
        chk("midreset_no_mddone", done_seen, 0);
`else
        start_op(2'b00, 32'd5, 32'd6);
        done_seen = 0;
        repeat (40) begin
            if (Busy !== 1'b0 || MDDone !== 1'b0) done_seen++;
            @(posedge clk); #2;
        end
        chk("nomd_busy_done_low", done_seen, 0);
        chk("nomd_lo_unchanged", LO, 32'h0);
        HIWrite = 1'b1; WData = 32'hDEADBEEF;
        @(posedge clk); #2;
        HIWrite = 1'b0; LOWrite = 1'b1; WData = 32'h01234567;
        @(posedge clk); #2;
        LOWrite = 1'b0;
        chk("nomd_mthi", HI, 32'hDEADBEEF);
        chk("nomd_mtlo", LO, 32'h01234567);
`endif

        @(posedge clk); #2;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

Execution unit on the consumer side of the 4-bit ALUControl command bus in the MIPS single-cycle datapath. It executes each ALUControl code combinationally, returning Result and Zero. It also contains an iterative multiply/divide engine with HI/LO registers, started by a pulse and reported through a Busy/MDDone handshake. Control and hazard logic stalls the PC while Busy is high.

## Interface
- WIDTH, 32, datapath width; the multiply/divide iteration count equals WIDTH.
- clk  in  1  rising-edge clock; the only clock.
- rst_n  in  1  reset, asynchronous, active-low.
- A  in  WIDTH  operand rs.
- B  in  WIDTH  operand rt or extended immediate.
- Shamt  in  5  shift amount (instr[10:6]).
- ALUControl  in  4  operation command.
- MDStart  in  1  one-cycle start pulse for mul/div.
- MDOp  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- HIWrite, LOWrite  in  1 each  MTHI/MTLO strobes.
- WData  in  WIDTH  MTHI/MTLO data.
- Result  out  WIDTH  combinational ALU result.
- Zero  out  1  Result == 0.
- HI, LO  out  WIDTH  registered HI/LO.
- Busy  out  1  mul/div in progress.
- MDDone  out  1  one-cycle completion pulse.

## Operation
- ALUControl codes:
  - 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0100 XOR, 1100 NOR.
  - 0111 SLT (signed), 1001 SLTU; Result is 1 or 0 zero-extended.
  - 1110 SLL B<<Shamt, 1111 SRL B>>Shamt, 1011 SRA B>>>Shamt.
  - 1010 LUI {B[15:0],16'h0}.
  - Any other code: Result = 0.
- ADD/SUB wrap modulo 2^WIDTH, with no overflow trap. Zero follows Result for every code.
- Mul/div FSM states: IDLE and RUN (5-bit counter), then DONE for one cycle, then back to IDLE.
  - IDLE -> RUN on MDStart=1, sampled at an edge. A and B are latched, and MDOp is latched.
  - MDStart while Busy=1 is ignored and not queued.
- Multiply: shift-add over magnitudes with a 2·WIDTH product. HI = upper half, LO = lower half.
  - MULT negates the product when the operand signs differ.
- Divide: restoring divide over magnitudes. LO = quotient, HI = remainder.
  - Quotient is negated when signs differ (DIV only). Remainder takes the dividend's sign.
  - DIV 0x80000000 / -1 gives LO = 0x80000000, HI = 0.
  - Divide by zero (both variants): LO = 0xFFFFFFFF, HI = latched A.
- HIWrite/LOWrite update HI/LO from WData at the edge, but only when Busy=0. They are ignored while Busy=1, including on the completing edge.
- HIWrite and MDStart in the same cycle: the write applies at that edge; the engine result overwrites it later.

## Timing
- Reset (async, immediate): Busy = 0, MDDone = 0, HI = 0, LO = 0, FSM = IDLE, counter = 0. Result and Zero track their inputs.
- Reset mid-operation aborts the computation; HI/LO are cleared and no MDDone is produced.
- Edge numbering: start is accepted at edge E0. Busy is 1 from after E0 through edge E32 (32 cycles).
- At E32, HI/LO are written and Busy falls. MDDone = 1 for exactly the cycle after E32.
- A new MDStart is accepted in the MDDone cycle (Busy=0), giving back-to-back throughput of one op per 33 cycles.
- A, B and MDOp may change after E0 without effect on the running operation.

## Configuration
- ALU_MULDIV_EN defined: the mul/div engine is present as described above.
- ALU_MULDIV_EN undefined:
  - The engine is not built.
  - MDStart and MDOp are ignored.
  - Busy and MDDone are tied to 0.
  - HI/LO remain, writable only via HIWrite/LOWrite.
  - ALU behaviour is unchanged.

## Test plan
- ALU sweep:
  - A = 0xF0F0F0F0, B = 0x0FF00FF0 with every code -> correct AND/OR/XOR/NOR/ADD/SUB.
  - Code 1101 -> Result = 0, Zero = 1.
  - SLT(-1, 1) = 1; SLTU(-1, 1) = 0.
  - SRA of 0x80000000 by 4 = 0xF8000000.
  - LUI with B = 0x1234 -> 0x12340000.
- MULT -3 × 7 -> HI = 0xFFFFFFFF, LO = 0xFFFFFFEB. Busy high for exactly 32 cycles, then MDDone for 1 cycle.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF -> HI = 0xFFFFFFFE, LO = 0x00000001.
- Divide cases:
  - DIV -7 / 2 -> LO = 0xFFFFFFFD, HI = 0xFFFFFFFF.
  - DIVU 7 / 0 -> LO = 0xFFFFFFFF, HI = 7.
  - DIV 0x80000000 / -1 -> LO = 0x80000000, HI = 0.
- Handshake during an operation:
  - A second MDStart and a HIWrite at cycle 10 of a MULT are both ignored.
  - The final HI/LO equal the first operation's result.
  - A HIWrite in the MDDone cycle takes effect.
- Mid-operation reset: rst_n low at cycle 15 of a DIV -> Busy, HI and LO go to 0 immediately, and no MDDone follows.
- Build without ALU_MULDIV_EN: MDStart is ignored, Busy stays 0, and MTHI of 0xDEADBEEF reads back on HI.
